// File: rtl/gba_pkg.sv
// Shared types and widths for the GBA cartridge ROM bus slave.
package gba_pkg;

    localparam int GBA_ADDR_W = 24;
    localparam int GBA_DATA_W = 16;
    localparam int ERR_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_READ   = 2'd2,
        ST_WRITE  = 2'd3
    } gba_state_e;

    // Add 0..2 error events to the counter, sticking at all-ones.
    function automatic logic [ERR_CNT_W-1:0] err_sat_add(
        input logic [ERR_CNT_W-1:0] cnt,
        input logic [1:0]           inc
    );
        logic [ERR_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(ERR_CNT_W-1){1'b0}}, inc};
        return sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : sum[ERR_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop chain used both as a metastability synchronizer for the
// GBA strobes and as a matching delay line for the AD/A bus.
module sync_ff #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift the input through DEPTH flops; reset to all-ones (strobes inactive).
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every stage is reset, not just the last one: a stale 0 left
        // in the middle of the chain would surface as a false strobe edge.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= {WIDTH{1'b1}};
            end
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous
            // stage's old value, which is what turns this into a shift chain.
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/gba_rom_bus.sv
// GBA cartridge ROM bus slave: synchronizes the GBA strobes, tracks the
// auto-incrementing halfword address, issues fetch/prefetch requests to the
// memory side, drives read data onto AD and forwards writes.
module gba_rom_bus
    import gba_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gba_ncs,
    input  logic        gba_nrd,
    input  logic        gba_nwr,
    input  logic [15:0] gba_ad_i,
    input  logic [7:0]  gba_a_i,
    output logic [15:0] gba_ad_o,
    output logic        gba_ad_oe,
    output logic        rd_req,
    output logic [23:0] rd_addr,
    input  logic        rd_valid,
    input  logic [15:0] rd_data,
    output logic        wr_valid,
    output logic [23:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        late,
    output logic [7:0]  err_cnt
);

    // Synchronized strobes and the equally delayed bus.
    logic [2:0]            strb_s;
    logic [GBA_ADDR_W-1:0] bus_s;
    logic                  ncs_s, nrd_s, nwr_s;

    sync_ff #(.WIDTH(3), .DEPTH(SYNC_STAGES)) u_sync_strb (
        .clk (clk),
        .rst (rst),
        .d   ({gba_ncs, gba_nrd, gba_nwr}),
        .q   (strb_s)
    );

    sync_ff #(.WIDTH(GBA_ADDR_W), .DEPTH(SYNC_STAGES)) u_sync_bus (
        .clk (clk),
        .rst (rst),
        .d   ({gba_a_i, gba_ad_i}),
        .q   (bus_s)
    );

    assign ncs_s = strb_s[2];
    assign nrd_s = strb_s[1];
    assign nwr_s = strb_s[0];

    // Edge detection and state.
    gba_state_e            state, state_next;
    logic                  ncs_q, nrd_q, nwr_q, ovl_q;
    logic                  ncs_fall, nrd_fall, nrd_rise, nwr_fall, nwr_rise;
    logic                  ovl, ovl_ev;
    logic                  data_ready;
    logic                  wr_abort;
    logic [GBA_ADDR_W-1:0] addr, addr_inc;
    logic [GBA_DATA_W-1:0] holding;

    // FSM control strobes.
    logic load_addr, inc_addr, issue_req, issue_wr, late_ev, abort_set, abort_clr;

    assign ncs_fall = ncs_q & ~ncs_s;
    assign nrd_fall = nrd_q & ~nrd_s;
    assign nrd_rise = ~nrd_q & nrd_s;
    assign nwr_fall = nwr_q & ~nwr_s;
    assign nwr_rise = ~nwr_q & nwr_s;
    assign ovl      = ~nrd_s & ~nwr_s;
    assign ovl_ev   = ovl & ~ovl_q;
    assign addr_inc = addr + 1'b1;

    // Previous synced strobe levels for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncs_q <= 1'b1;
            nrd_q <= 1'b1;
            nwr_q <= 1'b1;
            ovl_q <= 1'b0;
        end else begin
            ncs_q <= ncs_s;
            nrd_q <= nrd_s;
            nwr_q <= nwr_s;
            ovl_q <= ovl;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state and control-strobe decode; nCS high aborts any cycle.
    always_comb begin
        // NOTE: defaulting every output first means no path leaves a signal
        // unassigned, so no latch can be inferred.
        state_next = state;
        load_addr  = 1'b0;
        inc_addr   = 1'b0;
        issue_req  = 1'b0;
        issue_wr   = 1'b0;
        late_ev    = 1'b0;
        abort_set  = 1'b0;
        abort_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_next = ST_ACTIVE;
                    load_addr  = 1'b1;
                    issue_req  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ncs_s) begin
                    state_next = ST_IDLE;
                end else if (nrd_fall) begin
                    state_next = ST_READ;
                    late_ev    = ~data_ready;
                end else if (nwr_fall) begin
                    state_next = ST_WRITE;
                    abort_clr  = 1'b1;
                end
            end
            ST_READ: begin
                if (ncs_s) begin
                    state_next = ST_IDLE;
                end else if (nrd_rise) begin
                    state_next = ST_ACTIVE;
                    inc_addr   = 1'b1;
                    issue_req  = 1'b1;
                end
            end
            ST_WRITE: begin
                if (ncs_s) begin
                    state_next = ST_IDLE;
                end else begin
                    abort_set = ovl;
                    if (nwr_rise) begin
                        state_next = ST_ACTIVE;
                        issue_wr   = ~wr_abort;
                        inc_addr   = ~wr_abort;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Address, request/write pulses, holding register and error tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr       <= '0;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            holding    <= '0;
            data_ready <= 1'b0;
            wr_abort   <= 1'b0;
            late       <= 1'b0;
            err_cnt    <= '0;
        end else begin
            if (load_addr)     addr <= bus_s;
            else if (inc_addr) addr <= addr_inc;

            rd_req <= issue_req;
            if (issue_req) rd_addr <= load_addr ? bus_s : addr_inc;

            wr_valid <= issue_wr;
            if (issue_wr) begin
                wr_addr <= addr;
                wr_data <= bus_s[GBA_DATA_W-1:0];
            end

            if (rd_valid) holding <= rd_data;

            // A new request invalidates whatever is in the holding register.
            if (issue_req)     data_ready <= 1'b0;
            else if (rd_valid) data_ready <= 1'b1;

            if (abort_clr)      wr_abort <= 1'b0;
            else if (abort_set) wr_abort <= 1'b1;

            if (late_ev) late <= 1'b1;
            err_cnt <= err_sat_add(err_cnt, {1'b0, late_ev} + {1'b0, ovl_ev});
        end
    end

    // Drive AD only while a clean read strobe is held inside an active cycle.
    assign gba_ad_oe = (state == ST_READ) & ~ncs_s & ~nrd_s & nwr_s;
    assign gba_ad_o  = holding;

endmodule

// File: doc/gba_rom_bus.md
GBA_ROM_BUS -- requirements
Module: gba_rom_bus

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for GBA_nCS/nRD/nWR and sampled AD/A (legal 2..4).
REQ-002 SHALL have port clk, input, 1: system clock, 200 MHz; all state on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port gba_ncs, input, 1: raw cartridge ROM chip select, active low.
REQ-005 SHALL have port gba_nrd, input, 1: raw read strobe, active low.
REQ-006 SHALL have port gba_nwr, input, 1: raw write strobe, active low.
REQ-007 SHALL have port gba_ad_i, input, 16: AD pin input value.
REQ-008 SHALL have port gba_a_i, input, 8: A[23:16] pin input value.
REQ-009 SHALL have port gba_ad_o, output, 16: AD pin drive value.
REQ-010 SHALL have port gba_ad_oe, output, 1: AD output enable; top-level tristate uses it.
REQ-011 SHALL have port rd_req, output, 1: one-cycle fetch request pulse.
REQ-012 SHALL have port rd_addr, output, 24: halfword address of the fetch, valid with rd_req.
REQ-013 SHALL have port rd_valid, input, 1: fetch data valid pulse from the memory side.
REQ-014 SHALL have port rd_data, input, 16: fetch data, valid with rd_valid.
REQ-015 SHALL have port wr_valid, output, 1: one-cycle write pulse.
REQ-016 SHALL have port wr_addr, output, 24 and wr_data, output, 16: write address and data, valid with wr_valid.
REQ-017 SHALL have port late, output, 1: sticky flag for a read strobe that arrived before fetch data.
REQ-018 SHALL have port err_cnt, output, 8: saturating count of late reads plus nRD/nWR overlap events.

Function
REQ-019 SHALL pass nCS/nRD/nWR through SYNC_STAGES flops; AD/A SHALL be delayed by the same depth so that they stay aligned.
REQ-020 SHALL run FSM states IDLE, ACTIVE, READ, WRITE.
REQ-021 IDLE: on a synced nCS falling edge, SHALL latch addr={A,AD}, pulse rd_req with rd_addr=addr the next cycle, go to ACTIVE.
REQ-022 ACTIVE: on nRD falling, SHALL enter READ; on nWR falling, SHALL enter WRITE.
REQ-023 READ: gba_ad_oe=1 and gba_ad_o=holding register, from the cycle after the synced nRD falls.
REQ-024 On nRD rising, SHALL clear oe in the same cycle, increment addr, pulse rd_req (prefetch) with the new address, and return to ACTIVE.
REQ-025 WRITE: on nWR rising, SHALL pulse wr_valid with wr_addr=addr, wr_data=aligned AD sampled at the rising edge, increment addr, and return to ACTIVE.
REQ-026 The holding register SHALL load rd_data on every rd_valid; a data-ready flag SHALL be cleared by rd_req and set by rd_valid.
REQ-027 If nRD falls while data-ready=0, SHALL drive stale holding data, set late, and increment err_cnt.
REQ-028 Address increment SHALL wrap modulo 2^24 (0xFFFFFF -> 0x000000).
REQ-029 If nRD and nWR are both low, SHALL suppress wr_valid, keep oe=0, and increment err_cnt once per overlap.
REQ-030 A synced nCS rise SHALL force IDLE and oe=0 within 1 cycle from any state; a pending fetch completes into the holding register.
REQ-031 err_cnt SHALL saturate at 255.
REQ-032 late and err_cnt SHALL clear only on reset.

Reset
REQ-033 On reset, all outputs SHALL be 0: oe, rd_req, wr_valid, late, err_cnt, addresses and data.
REQ-034 On reset, the FSM SHALL enter IDLE, synchronizers SHALL be set to 1 (inactive), and data-ready SHALL be 0.
REQ-035 Reset asserted mid-read SHALL deassert gba_ad_oe asynchronously.

Structure
REQ-036 A shared package gba_pkg SHALL hold the FSM state enum, GBA_ADDR_W=24, GBA_DATA_W=16, and ERR_CNT_W=8.
REQ-037 A sub-module sync_ff (parameterised width and depth, reset value 1) SHALL implement the synchronizers.

Verification
REQ-038 Test: nCS falls with A=0x08, AD=0x1234 -> one rd_req with rd_addr=0x081234; rd_valid with 0xBEEF before nRD -> AD driven 0xBEEF during nRD.
REQ-039 Test: 3 sequential nRD pulses -> rd_addr 0x081235, 0x081236, 0x081237; oe low between strobes.
REQ-040 Test: start address 0xFFFFFF, one read -> prefetch rd_addr=0x000000.
REQ-041 Test: nWR pulse with AD=0xA55A at 0x000010 -> wr_valid for 1 cycle, wr_addr=0x000010, wr_data=0xA55A, next addr 0x000011.
REQ-042 Test: nRD falls with no rd_valid -> late=1, err_cnt=1; then nRD+nWR overlap -> err_cnt=2, no wr_valid.
REQ-043 Test: rst asserted during READ -> oe=0 immediately, FSM IDLE, err_cnt=0.
